// File: rtl/load_store_sequencer_pkg.sv
// Shared constants for the load/store sequencer and the memory interface.
// - Datapath widths (address, data, register index).
// - FSM state encoding for the sequencer.
// - Word-type encoding as seen on the memory interface.
// - Outcome encoding for the sequencer's DONE state.
package load_store_sequencer_pkg;

  localparam int unsigned AddrWidth   = 12;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned RegIdxWidth = 4;

  // Sequencer FSM states
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Access sizes; 2'b11 is illegal
  localparam logic [1:0] WtByte = 2'b00;
  localparam logic [1:0] WtHalf = 2'b01;
  localparam logic [1:0] WtWord = 2'b10;

  // What the DONE state reports
  localparam logic [1:0] OutLoad    = 2'd0;
  localparam logic [1:0] OutStore   = 2'd1;
  localparam logic [1:0] OutAddrErr = 2'd2;
  localparam logic [1:0] OutTimeout = 2'd3;

endpackage

// File: rtl/load_store_sequencer_ea_check.sv
// Effective-address adder and address error detection (purely combinational).
// Ports:
//   base_i      : unsigned base address
//   offset_i    : two's-complement offset
//   word_type_i : access size (byte/halfword/word, 11 illegal)
//   ea_o        : low address bits of base + sign_extend(offset)
//   err_o       : request must be rejected
module load_store_sequencer_ea_check
  import load_store_sequencer_pkg::*;
(
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] offset_i,
  input  logic [1:0]           word_type_i,
  output logic [AddrWidth-1:0] ea_o,
  output logic                 err_o
);

  logic [AddrWidth:0] sum;
  logic               range_err;
  logic               align_err;
  logic               wrap_err;
  logic               type_err;

  always_comb begin
    sum  = {1'b0, base_i} + {offset_i[AddrWidth-1], offset_i};
    ea_o = sum[AddrWidth-1:0];
    // Any in-range result has the top bit clear; overflow past 0xFFF and
    // negative results (wrapped modulo 2^13) both land with it set.
    range_err = sum[AddrWidth];
    align_err = ((word_type_i == WtHalf) || (word_type_i == WtWord)) && ea_o[0];
    wrap_err  = (word_type_i == WtWord) && (ea_o == '1);
    type_err  = (word_type_i == 2'b11);
    err_o     = range_err || align_err || wrap_err || type_err;
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Load/store sequencer between the execute stage and the memory interface.
// Accepts one request at a time, checks its effective address, strobes the
// memory interface once, waits for completion (or times out), and reports
// load data to writeback or a one-cycle status pulse.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   req_*                   : request from the pipeline (valid/ready handshake)
//   mi_*                    : memory interface operands, strobes and status
//   wb_valid_o/wb_rd_o/wb_data_o : load writeback
//   store_done_o, err_addr_o, err_timeout_o : one-cycle status pulses
//   lsu_busy_o              : pipeline stall, inverse of req_ready_o
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_is_store_i,
  input  logic [11:0] req_base_i,
  input  logic [11:0] req_offset_i,
  input  logic [31:0] req_data_i,
  input  logic [1:0]  req_word_type_i,
  input  logic        req_is_signed_i,
  input  logic [3:0]  req_rd_i,
  output logic [11:0] mi_address_o,
  output logic [31:0] mi_data_in_o,
  output logic        mi_load_o,
  output logic        mi_store_o,
  output logic        mi_is_signed_o,
  output logic [1:0]  mi_word_type_o,
  input  logic [31:0] mi_data_out_i,
  input  logic        mi_output_valid_i,
  input  logic        mi_write_ready_i,
  input  logic        mi_busy_i,
  output logic        wb_valid_o,
  output logic [3:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        store_done_o,
  output logic        err_addr_o,
  output logic        err_timeout_o,
  output logic        lsu_busy_o
);

  localparam int unsigned CntW =
      ($clog2(TimeoutCycles + 1) > 4) ? $clog2(TimeoutCycles + 1) : 4;
  // Timeout is taken on the WAIT cycle whose increment would reach TimeoutCycles
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [1:0]           state_q, state_d;
  logic [1:0]           outcome_q, outcome_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_store_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic [1:0]           word_type_q;
  logic                 is_signed_q;
  logic [3:0]           rd_q;
  logic [DataWidth-1:0] wb_data_q;
  logic [3:0]           wb_rd_q;

  logic [AddrWidth-1:0] ea;
  logic                 ea_err;
  logic                 xfer;
  logic                 complete;
  logic                 load_complete;
  logic                 issue_go;
  logic                 in_done;

  load_store_sequencer_ea_check u_ea_check (
    .base_i      (req_base_i),
    .offset_i    (req_offset_i),
    .word_type_i (req_word_type_i),
    .ea_o        (ea),
    .err_o       (ea_err)
  );

  assign req_ready_o   = (state_q == StIdle) && !reset_i;
  assign lsu_busy_o    = !req_ready_o;
  assign xfer          = req_valid_i && req_ready_o;
  // Only the completion strobe matching the access type counts
  assign complete      = is_store_q ? mi_write_ready_i : mi_output_valid_i;
  assign load_complete = (state_q == StWait) && !is_store_q && mi_output_valid_i;

  always_comb begin
    state_d   = state_q;
    outcome_d = outcome_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          if (ea_err) begin
            state_d   = StDone;
            outcome_d = OutAddrErr;
          end else begin
            state_d   = StIssue;
            outcome_d = req_is_store_i ? OutStore : OutLoad;
          end
        end
      end
      StIssue: begin
        if (!mi_busy_i) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (complete) begin
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          outcome_d = OutTimeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      outcome_q   <= OutLoad;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      word_type_q <= WtByte;
      is_signed_q <= 1'b0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
    end else begin
      state_q   <= state_d;
      outcome_q <= outcome_d;
      cnt_q     <= cnt_d;
      if (xfer) begin
        is_store_q  <= req_is_store_i;
        addr_q      <= ea;
        data_q      <= req_data_i;
        word_type_q <= req_word_type_i;
        is_signed_q <= req_is_signed_i;
        rd_q        <= req_rd_i;
      end
      if (load_complete) begin
        wb_data_q <= mi_data_out_i;
        wb_rd_q   <= rd_q;
      end
    end
  end

  // Strobes and pulses are gated by reset so they drop in the reset cycle
  assign issue_go = (state_q == StIssue) && !mi_busy_i && !reset_i;
  assign in_done  = (state_q == StDone) && !reset_i;

  assign mi_address_o   = addr_q;
  assign mi_data_in_o   = data_q;
  assign mi_is_signed_o = is_signed_q;
  assign mi_word_type_o = word_type_q;
  assign mi_load_o      = issue_go && !is_store_q;
  assign mi_store_o     = issue_go && is_store_q;

  assign wb_valid_o    = in_done && (outcome_q == OutLoad);
  assign store_done_o  = in_done && (outcome_q == OutStore);
  assign err_addr_o    = in_done && (outcome_q == OutAddrErr);
  assign err_timeout_o = in_done && (outcome_q == OutTimeout);
  assign wb_data_o     = wb_data_q;
  assign wb_rd_o       = wb_rd_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: each task drives one scenario and
// compares outputs against hand-computed values. Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns after that.
module tb_load_store_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [11:0] req_base = '0;
  logic [11:0] req_offset = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_word_type = '0;
  logic        req_is_signed = 1'b0;
  logic [3:0]  req_rd = '0;
  logic [11:0] mi_address;
  logic [31:0] mi_data_in;
  logic        mi_load, mi_store, mi_is_signed;
  logic [1:0]  mi_word_type;
  logic [31:0] mi_data_out = '0;
  logic        mi_output_valid = 1'b0;
  logic        mi_write_ready = 1'b0;
  logic        mi_busy = 1'b0;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done, err_addr, err_timeout, lsu_busy;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  always #5 clk = ~clk;

  load_store_sequencer #(.TimeoutCycles(15)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_is_store_i    (req_is_store),
    .req_base_i        (req_base),
    .req_offset_i      (req_offset),
    .req_data_i        (req_data),
    .req_word_type_i   (req_word_type),
    .req_is_signed_i   (req_is_signed),
    .req_rd_i          (req_rd),
    .mi_address_o      (mi_address),
    .mi_data_in_o      (mi_data_in),
    .mi_load_o         (mi_load),
    .mi_store_o        (mi_store),
    .mi_is_signed_o    (mi_is_signed),
    .mi_word_type_o    (mi_word_type),
    .mi_data_out_i     (mi_data_out),
    .mi_output_valid_i (mi_output_valid),
    .mi_write_ready_i  (mi_write_ready),
    .mi_busy_i         (mi_busy),
    .wb_valid_o        (wb_valid),
    .wb_rd_o           (wb_rd),
    .wb_data_o         (wb_data),
    .store_done_o      (store_done),
    .err_addr_o        (err_addr),
    .err_timeout_o     (err_timeout),
    .lsu_busy_o        (lsu_busy)
  );

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [11:0] b, input logic [11:0] o,
                           input logic [31:0] d, input logic [1:0] wt, input logic sg,
                           input logic [3:0] rd);
    req_valid = 1'b1; req_is_store = st; req_base = b; req_offset = o;
    req_data = d; req_word_type = wt; req_is_signed = sg; req_rd = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_step();
    clk_step();
    #1;
    vec_cnt++; if (req_ready !== 1'b0) begin miscmp_cnt++; $display("FAIL rst_ready: got %0b want 0", req_ready); end
    vec_cnt++; if (lsu_busy !== 1'b1) begin miscmp_cnt++; $display("FAIL rst_busy: got %0b want 1", lsu_busy); end
    vec_cnt++; if ({mi_load, mi_store, mi_is_signed, mi_word_type} !== 5'b0) begin miscmp_cnt++; $display("FAIL rst_mi_ctl: got %b want 0", {mi_load, mi_store, mi_is_signed, mi_word_type}); end
    vec_cnt++; if ({mi_address, mi_data_in} !== 44'h0) begin miscmp_cnt++; $display("FAIL rst_mi_data: got %h want 0", {mi_address, mi_data_in}); end
    vec_cnt++; if ({wb_valid, store_done, err_addr, err_timeout} !== 4'b0) begin miscmp_cnt++; $display("FAIL rst_pulses: got %b want 0", {wb_valid, store_done, err_addr, err_timeout}); end
    vec_cnt++; if ({wb_rd, wb_data} !== 36'h0) begin miscmp_cnt++; $display("FAIL rst_wb: got %h want 0", {wb_rd, wb_data}); end
    clk_step();
    reset = 1'b0;
    #1;
    vec_cnt++; if (req_ready !== 1'b1) begin miscmp_cnt++; $display("FAIL rst_release_ready: got %0b want 1", req_ready); end
    vec_cnt++; if (lsu_busy !== 1'b0) begin miscmp_cnt++; $display("FAIL rst_release_busy: got %0b want 0", lsu_busy); end
  endtask

  task automatic test_load_word();
    clk_step();
    drive_req(1'b0, 12'h100, 12'h004, 32'h0, 2'b10, 1'b0, 4'h5);
    #1;
    vec_cnt++; if (req_ready !== 1'b1) begin miscmp_cnt++; $display("FAIL lw_accept: got %0b want 1", req_ready); end
    clk_step();
    req_valid = 1'b0;
    #1;
    vec_cnt++; if ({mi_load, mi_store} !== 2'b10) begin miscmp_cnt++; $display("FAIL lw_strobe: got %b want 10", {mi_load, mi_store}); end
    vec_cnt++; if (mi_address !== 12'h104) begin miscmp_cnt++; $display("FAIL lw_addr: got %h want 104", mi_address); end
    vec_cnt++; if (mi_word_type !== 2'b10) begin miscmp_cnt++; $display("FAIL lw_wt: got %b want 10", mi_word_type); end
    for (int c = 2; c <= 6; c++) begin
      clk_step();
      mi_write_ready  = (c == 2);  // wrong-type completion, must be ignored
      mi_output_valid = (c == 4);
      mi_data_out     = (c == 4) ? 32'hDEADBEEF : 32'h0;
      #1;
      vec_cnt++; if (mi_load !== 1'b0) begin miscmp_cnt++; $display("FAIL lw_no_restrobe c%0d: got %0b want 0", c, mi_load); end
      vec_cnt++; if (wb_valid !== (c == 5)) begin miscmp_cnt++; $display("FAIL lw_wb_valid c%0d: got %0b want %0b", c, wb_valid, (c == 5)); end
      if (c <= 5) begin
        vec_cnt++; if (mi_address !== 12'h104) begin miscmp_cnt++; $display("FAIL lw_addr_hold c%0d: got %h want 104", c, mi_address); end
      end
      if (c == 5) begin
        vec_cnt++; if (wb_data !== 32'hDEADBEEF) begin miscmp_cnt++; $display("FAIL lw_wb_data: got %h want deadbeef", wb_data); end
        vec_cnt++; if (wb_rd !== 4'h5) begin miscmp_cnt++; $display("FAIL lw_wb_rd: got %h want 5", wb_rd); end
      end
      if (c == 6) begin
        vec_cnt++; if (req_ready !== 1'b1) begin miscmp_cnt++; $display("FAIL lw_ready_after: got %0b want 1", req_ready); end
      end
    end
  endtask

  task automatic test_store_half();
    int stores = 0;
    clk_step();
    drive_req(1'b1, 12'h010, 12'hFFE, 32'h0000ABCD, 2'b01, 1'b0, 4'h0);
    #1;
    clk_step();
    req_valid = 1'b0;
    #1;
    stores += int'(mi_store);
    vec_cnt++; if (mi_load !== 1'b0) begin miscmp_cnt++; $display("FAIL sh_no_load: got %0b want 0", mi_load); end
    vec_cnt++; if (mi_address !== 12'h00E) begin miscmp_cnt++; $display("FAIL sh_addr: got %h want 00e", mi_address); end
    vec_cnt++; if (mi_data_in !== 32'h0000ABCD) begin miscmp_cnt++; $display("FAIL sh_data: got %h want 0000abcd", mi_data_in); end
    vec_cnt++; if (mi_word_type !== 2'b01) begin miscmp_cnt++; $display("FAIL sh_wt: got %b want 01", mi_word_type); end
    clk_step();
    mi_write_ready = 1'b1;
    mi_output_valid = 1'b1;
    #1;
    stores += int'(mi_store);
    vec_cnt++; if (store_done !== 1'b0) begin miscmp_cnt++; $display("FAIL sh_done_early: got %0b want 0", store_done); end
    clk_step();
    mi_write_ready = 1'b0;
    mi_output_valid = 1'b0;
    #1;
    stores += int'(mi_store);
    vec_cnt++; if (store_done !== 1'b1) begin miscmp_cnt++; $display("FAIL sh_store_done: got %0b want 1", store_done); end
    vec_cnt++; if (wb_valid !== 1'b0) begin miscmp_cnt++; $display("FAIL sh_no_wb: got %0b want 0", wb_valid); end
    vec_cnt++; if (wb_data !== 32'hDEADBEEF) begin miscmp_cnt++; $display("FAIL sh_wb_hold: got %h want deadbeef", wb_data); end
    clk_step();
    #1;
    stores += int'(mi_store);
    vec_cnt++; if (store_done !== 1'b0) begin miscmp_cnt++; $display("FAIL sh_done_pulse: got %0b want 0", store_done); end
    vec_cnt++; if (req_ready !== 1'b1) begin miscmp_cnt++; $display("FAIL sh_turnaround: got %0b want 1", req_ready); end
    vec_cnt++; if (stores !== 1) begin miscmp_cnt++; $display("FAIL sh_store_count: got %0d want 1", stores); end
  endtask

  task automatic test_addr_errors();
    logic [11:0] eb [5] = '{12'hFFF, 12'hFFE, 12'h100, 12'h000, 12'h100};
    logic [11:0] eo [5] = '{12'h001, 12'h001, 12'h001, 12'hFFF, 12'h000};
    logic [1:0]  ew [5] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11};
    for (int i = 0; i < 5; i++) begin
      clk_step();
      drive_req(1'b0, eb[i], eo[i], 32'h0, ew[i], 1'b0, 4'h1);
      #1;
      clk_step();
      req_valid = 1'b0;
      #1;
      vec_cnt++; if (err_addr !== 1'b1) begin miscmp_cnt++; $display("FAIL ae%0d_err: got %0b want 1", i, err_addr); end
      vec_cnt++; if ({mi_load, mi_store} !== 2'b00) begin miscmp_cnt++; $display("FAIL ae%0d_strobe: got %b want 00", i, {mi_load, mi_store}); end
      vec_cnt++; if (req_ready !== 1'b0) begin miscmp_cnt++; $display("FAIL ae%0d_ready_done: got %0b want 0", i, req_ready); end
      clk_step();
      #1;
      vec_cnt++; if ({err_addr, wb_valid} !== 2'b00) begin miscmp_cnt++; $display("FAIL ae%0d_after: got %b want 00", i, {err_addr, wb_valid}); end
      vec_cnt++; if (req_ready !== 1'b1) begin miscmp_cnt++; $display("FAIL ae%0d_ready: got %0b want 1", i, req_ready); end
    end
    // Byte access at 0xFFF is legal
    drive_req(1'b0, 12'hFFE, 12'h001, 32'h0, 2'b00, 1'b0, 4'h3);
    clk_step();
    req_valid = 1'b0;
    #1;
    vec_cnt++; if ({err_addr, mi_load} !== 2'b01) begin miscmp_cnt++; $display("FAIL ae_byte_fff: got %b want 01", {err_addr, mi_load}); end
    vec_cnt++; if (mi_address !== 12'hFFF) begin miscmp_cnt++; $display("FAIL ae_byte_addr: got %h want fff", mi_address); end
    clk_step();
    mi_output_valid = 1'b1;
    mi_data_out = 32'h00000012;
    #1;
    clk_step();
    mi_output_valid = 1'b0;
    #1;
    vec_cnt++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'h3, 32'h00000012}) begin miscmp_cnt++; $display("FAIL ae_byte_wb: got %b/%h/%h want 1/3/00000012", wb_valid, wb_rd, wb_data); end
    clk_step();
  endtask

  task automatic test_back_pressure();
    int loads = 0;
    mi_busy = 1'b1;
    drive_req(1'b0, 12'h200, 12'h010, 32'h0, 2'b00, 1'b1, 4'h9);
    #1;
    for (int c = 1; c <= 9; c++) begin
      clk_step();
      req_valid = 1'b0;
      mi_busy = (c <= 5);
      mi_output_valid = (c == 7);
      mi_data_out = (c == 7) ? 32'hFFFFFF80 : 32'h0;
      #1;
      loads += int'(mi_load);
      vec_cnt++; if (mi_load !== (c == 6)) begin miscmp_cnt++; $display("FAIL bp_strobe c%0d: got %0b want %0b", c, mi_load, (c == 6)); end
      if (c <= 8) begin
        vec_cnt++; if ({mi_address, mi_is_signed} !== {12'h210, 1'b1}) begin miscmp_cnt++; $display("FAIL bp_operands c%0d: got %h/%0b want 210/1", c, mi_address, mi_is_signed); end
        vec_cnt++; if (lsu_busy !== 1'b1) begin miscmp_cnt++; $display("FAIL bp_busy c%0d: got %0b want 1", c, lsu_busy); end
      end
      if (c == 8) begin
        vec_cnt++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'h9, 32'hFFFFFF80}) begin miscmp_cnt++; $display("FAIL bp_wb: got %b/%h/%h want 1/9/ffffff80", wb_valid, wb_rd, wb_data); end
      end
    end
    vec_cnt++; if (loads !== 1) begin miscmp_cnt++; $display("FAIL bp_load_count: got %0d want 1", loads); end
    vec_cnt++; if (req_ready !== 1'b1) begin miscmp_cnt++; $display("FAIL bp_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_timeout();
    // No completion: strobe in cycle 1, err_timeout in cycle 17
    drive_req(1'b0, 12'h300, 12'h000, 32'h0, 2'b10, 1'b0, 4'h7);
    clk_step();
    req_valid = 1'b0;
    #1;
    vec_cnt++; if (mi_load !== 1'b1) begin miscmp_cnt++; $display("FAIL to_strobe: got %0b want 1", mi_load); end
    for (int c = 2; c <= 18; c++) begin
      clk_step();
      mi_write_ready = (c == 5);  // wrong-type completion
      #1;
      vec_cnt++; if (err_timeout !== (c == 17)) begin miscmp_cnt++; $display("FAIL to_pulse c%0d: got %0b want %0b", c, err_timeout, (c == 17)); end
      vec_cnt++; if ({wb_valid, mi_load} !== 2'b00) begin miscmp_cnt++; $display("FAIL to_quiet c%0d: got %b want 00", c, {wb_valid, mi_load}); end
      if (c == 18) begin
        vec_cnt++; if (req_ready !== 1'b1) begin miscmp_cnt++; $display("FAIL to_ready: got %0b want 1", req_ready); end
      end
    end
    // Completion on the last WAIT cycle beats the timeout
    drive_req(1'b0, 12'h300, 12'h004, 32'h0, 2'b10, 1'b0, 4'h6);
    clk_step();
    req_valid = 1'b0;
    #1;
    for (int c = 2; c <= 17; c++) begin
      clk_step();
      mi_output_valid = (c == 16);
      mi_data_out = (c == 16) ? 32'h0BADF00D : 32'h0;
      #1;
      if (c == 17) begin
        vec_cnt++; if ({wb_valid, err_timeout} !== 2'b10) begin miscmp_cnt++; $display("FAIL to_race: got %b want 10", {wb_valid, err_timeout}); end
        vec_cnt++; if ({wb_rd, wb_data} !== {4'h6, 32'h0BADF00D}) begin miscmp_cnt++; $display("FAIL to_race_wb: got %h/%h want 6/0badf00d", wb_rd, wb_data); end
      end
    end
    clk_step();
  endtask

  task automatic test_reset_mid();
    // Reset while in WAIT
    drive_req(1'b0, 12'h040, 12'h001, 32'h0, 2'b00, 1'b0, 4'h2);
    clk_step();
    req_valid = 1'b0;
    #1;
    vec_cnt++; if (mi_load !== 1'b1) begin miscmp_cnt++; $display("FAIL rm_strobe: got %0b want 1", mi_load); end
    clk_step();
    clk_step();
    reset = 1'b1;
    #1;
    vec_cnt++; if (req_ready !== 1'b0) begin miscmp_cnt++; $display("FAIL rm_ready_in_reset: got %0b want 0", req_ready); end
    clk_step();
    reset = 1'b0;
    #1;
    vec_cnt++; if (req_ready !== 1'b1) begin miscmp_cnt++; $display("FAIL rm_ready: got %0b want 1", req_ready); end
    vec_cnt++; if ({mi_load, mi_store, mi_address} !== 14'h0) begin miscmp_cnt++; $display("FAIL rm_mi: got %h want 0", {mi_load, mi_store, mi_address}); end
    clk_step();
    mi_output_valid = 1'b1;
    mi_data_out = 32'h55555555;
    #1;
    clk_step();
    mi_output_valid = 1'b0;
    #1;
    vec_cnt++; if ({wb_valid, err_timeout, store_done} !== 3'b000) begin miscmp_cnt++; $display("FAIL rm_late_valid: got %b want 000", {wb_valid, err_timeout, store_done}); end
    vec_cnt++; if (wb_data !== 32'h0) begin miscmp_cnt++; $display("FAIL rm_wb_data: got %h want 0", wb_data); end
    // Reset while the strobe is up: it must drop in that same cycle
    drive_req(1'b1, 12'h080, 12'h000, 32'h1234, 2'b10, 1'b0, 4'h0);
    clk_step();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    vec_cnt++; if ({mi_load, mi_store} !== 2'b00) begin miscmp_cnt++; $display("FAIL rm_strobe_drop: got %b want 00", {mi_load, mi_store}); end
    clk_step();
    reset = 1'b0;
    #1;
    vec_cnt++; if ({req_ready, mi_store} !== 2'b10) begin miscmp_cnt++; $display("FAIL rm_after_issue: got %b want 10", {req_ready, mi_store}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_word();
    test_store_half();
    test_addr_errors();
    test_back_pressure();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
